// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_arb_pkg: shared encodings and constants for the I2C Wishbone arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_A_IDLE  = 2'd0,
    ST_A_SCRUB = 2'd1,
    ST_A_OWN   = 2'd2
  } arb_state_e;

  localparam logic [2:0] CR_ADDR            = 3'b100;
  localparam logic [7:0] SCRUB_DATA_DEFAULT = 8'h01;

  localparam logic REQ_TRUSTED   = 1'b0;
  localparam logic REQ_UNTRUSTED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_arb_hold_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_arb_hold_timer: saturating hold counter with clear/enable and limit flag
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_arb_hold_timer import i2c_arb_pkg::*; #(
  parameter int HOLD_W = 9,
  parameter int LIMIT  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic at_limit_o
);

  localparam logic [HOLD_W-1:0] LIMIT_C = HOLD_W'(LIMIT);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {HOLD_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables forced revoke altogether.
  assign at_limit_o = (LIMIT != 0) && (cnt_q >= LIMIT_C);

endmodule
`default_nettype wire

// File: rtl/i2c_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_wb_arbiter: per-session arbiter sharing the I2C core Wishbone port
// Rev 1.0
// ----------------------------------------------------------------------------
module i2c_wb_arbiter import i2c_arb_pkg::*; #(
  parameter int         MAX_HOLD   = 256,
  parameter int         HOLD_W     = 9,
  parameter logic [7:0] SCRUB_DATA = SCRUB_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  output logic [1:0]  gnt_o,
  input  logic [5:0]  m_wb_addr_i,
  input  logic [15:0] m_wb_wr_data_i,
  input  logic [1:0]  m_wb_we_i,
  input  logic [1:0]  m_wb_stb_i,
  input  logic [1:0]  m_wb_cyc_i,
  output logic [15:0] m_wb_rd_data_o,
  output logic [1:0]  m_wb_ack_o,
  output logic [2:0]  s_wb_addr_o,
  output logic [7:0]  s_wb_wr_data_o,
  output logic        s_wb_we_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic [7:0]  s_wb_rd_data_i,
  input  logic        s_wb_ack_i,
  output logic        owner_domain_o,
  output logic        revoke_err_o
);

  arb_state_e state_q;
  logic [1:0] gnt_q;
  logic       owner_q;
  logic       last_owner_q;
  logic       prev_valid_q;
  logic       revoke_q;
  logic       scrub_act_q;

  logic       w_own;
  logic       w_winner;
  logic       w_own_cyc;
  logic       w_release;
  logic       w_revoke;
  logic       w_at_limit;

  assign w_own     = (state_q == ST_A_OWN);
  // With both requests pending, the side that did not own last goes first.
  assign w_winner  = (req_i == 2'b11) ? ~last_owner_q : req_i[1];
  assign w_own_cyc = m_wb_cyc_i[owner_q];
  assign w_release = w_own && !req_i[owner_q] && !w_own_cyc;
  assign w_revoke  = w_own && w_at_limit && !w_own_cyc && !w_release;

  i2c_arb_hold_timer #(
    .HOLD_W (HOLD_W),
    .LIMIT  (MAX_HOLD)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (!w_own),
    .en_i       (w_own && req_i[~owner_q]),
    .at_limit_o (w_at_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_A_IDLE;
      gnt_q        <= 2'b00;
      owner_q      <= REQ_TRUSTED;
      last_owner_q <= REQ_UNTRUSTED;
      prev_valid_q <= 1'b0;
      revoke_q     <= 1'b0;
      scrub_act_q  <= 1'b0;
    end else begin
      revoke_q <= 1'b0;
      case (state_q)
        ST_A_IDLE: begin
          if (|req_i) begin
            owner_q <= w_winner;
            if (prev_valid_q && (w_winner != owner_q)) begin
              state_q     <= ST_A_SCRUB;
              scrub_act_q <= 1'b1;
            end else begin
              state_q <= ST_A_OWN;
              gnt_q   <= {w_winner, ~w_winner};
            end
          end
        end
        ST_A_SCRUB: begin
          if (s_wb_ack_i) begin
            scrub_act_q <= 1'b0;
            if (req_i[owner_q]) begin
              state_q <= ST_A_OWN;
              gnt_q   <= {owner_q, ~owner_q};
            end else begin
              state_q <= ST_A_IDLE;
            end
          end
        end
        ST_A_OWN: begin
          if (w_release) begin
            state_q      <= ST_A_IDLE;
            gnt_q        <= 2'b00;
            last_owner_q <= owner_q;
            prev_valid_q <= 1'b1;
          end else if (w_revoke) begin
            state_q      <= ST_A_SCRUB;
            scrub_act_q  <= 1'b1;
            gnt_q        <= 2'b00;
            revoke_q     <= 1'b1;
            last_owner_q <= owner_q;
            prev_valid_q <= 1'b1;
            owner_q      <= ~owner_q;
          end
        end
        default: state_q <= ST_A_IDLE;
      endcase
    end
  end

  // Owner lanes pass straight through; every non-owner lane stays at zero.
  always_comb begin
    s_wb_addr_o    = 3'b000;
    s_wb_wr_data_o = 8'h00;
    s_wb_we_o      = 1'b0;
    s_wb_stb_o     = 1'b0;
    s_wb_cyc_o     = 1'b0;
    m_wb_rd_data_o = 16'h0000;
    m_wb_ack_o     = 2'b00;
    if (w_own) begin
      s_wb_addr_o    = owner_q ? m_wb_addr_i[5:3] : m_wb_addr_i[2:0];
      s_wb_wr_data_o = owner_q ? m_wb_wr_data_i[15:8] : m_wb_wr_data_i[7:0];
      s_wb_we_o      = m_wb_we_i[owner_q];
      s_wb_stb_o     = m_wb_stb_i[owner_q];
      s_wb_cyc_o     = m_wb_cyc_i[owner_q];
      m_wb_ack_o[owner_q] = s_wb_ack_i;
      if (owner_q) begin
        m_wb_rd_data_o[15:8] = s_wb_rd_data_i;
      end else begin
        m_wb_rd_data_o[7:0]  = s_wb_rd_data_i;
      end
    end else if (scrub_act_q) begin
      s_wb_addr_o    = CR_ADDR;
      s_wb_wr_data_o = SCRUB_DATA;
      s_wb_we_o      = 1'b1;
      s_wb_stb_o     = 1'b1;
      s_wb_cyc_o     = 1'b1;
    end
  end

  assign gnt_o          = gnt_q;
  assign owner_domain_o = owner_q;
  assign revoke_err_o   = revoke_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2c_wb_arbiter: self-checking bench for the I2C Wishbone arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_i2c_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [5:0]  m_addr;
  logic [15:0] m_wd;
  logic [1:0]  m_we, m_stb, m_cyc;
  logic [15:0] m_rd;
  logic [1:0]  m_ack;
  logic [2:0]  s_addr;
  logic [7:0]  s_wd;
  logic        s_we, s_stb, s_cyc;
  logic [7:0]  s_rd;
  logic        s_ack;
  logic        owner;
  logic        revoke;

  int checks = 0;
  int errors = 0;

  i2c_wb_arbiter #(
    .MAX_HOLD   (16),
    .HOLD_W     (9),
    .SCRUB_DATA (8'h01)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .gnt_o          (gnt),
    .m_wb_addr_i    (m_addr),
    .m_wb_wr_data_i (m_wd),
    .m_wb_we_i      (m_we),
    .m_wb_stb_i     (m_stb),
    .m_wb_cyc_i     (m_cyc),
    .m_wb_rd_data_o (m_rd),
    .m_wb_ack_o     (m_ack),
    .s_wb_addr_o    (s_addr),
    .s_wb_wr_data_o (s_wd),
    .s_wb_we_o      (s_we),
    .s_wb_stb_o     (s_stb),
    .s_wb_cyc_o     (s_cyc),
    .s_wb_rd_data_i (s_rd),
    .s_wb_ack_i     (s_ack),
    .owner_domain_o (owner),
    .revoke_err_o   (revoke)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl fields are {we, stb, cyc}; "m" is the owner lane, "o" the other lane.
  typedef struct {
    logic [2:0]  m_addr; logic [7:0] m_wd; logic [2:0] m_ctl;
    logic [2:0]  o_addr; logic [7:0] o_wd; logic [2:0] o_ctl;
    logic [7:0]  s_rd;   logic       s_ack;
    logic [2:0]  e_addr; logic [7:0] e_wd; logic [2:0] e_ctl;
    logic [15:0] e_rd;   logic [1:0] e_ack;
  } vec_t;

  typedef struct {
    logic [2:0] addr; logic [7:0] wd; logic [2:0] ctl;
    logic [15:0] rd;  logic [1:0] ack;
  } exp_t;

  vec_t vt [8];
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_bus();
    m_addr = '0; m_wd = '0; m_we = '0; m_stb = '0; m_cyc = '0;
    s_rd = '0; s_ack = 1'b0;
  endtask

  task automatic apply(input int lo, input int hi, input bit own);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      if (own) begin
        m_addr = {vt[i].m_addr, vt[i].o_addr};
        m_wd   = {vt[i].m_wd, vt[i].o_wd};
        {m_we[1], m_stb[1], m_cyc[1]} = vt[i].m_ctl;
        {m_we[0], m_stb[0], m_cyc[0]} = vt[i].o_ctl;
      end else begin
        m_addr = {vt[i].o_addr, vt[i].m_addr};
        m_wd   = {vt[i].o_wd, vt[i].m_wd};
        {m_we[0], m_stb[0], m_cyc[0]} = vt[i].m_ctl;
        {m_we[1], m_stb[1], m_cyc[1]} = vt[i].o_ctl;
      end
      s_rd  = vt[i].s_rd;
      s_ack = vt[i].s_ack;
      e.addr = vt[i].e_addr; e.wd = vt[i].e_wd; e.ctl = vt[i].e_ctl;
      e.rd   = vt[i].e_rd;   e.ack = vt[i].e_ack;
      sb.push_back(e);
      #2;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_s_addr", i), s_addr, e.addr);
        chk($sformatf("v%0d_s_wd", i), s_wd, e.wd);
        chk($sformatf("v%0d_s_ctl", i), {s_we, s_stb, s_cyc}, e.ctl);
        chk($sformatf("v%0d_m_rd", i), m_rd, e.rd);
        chk($sformatf("v%0d_m_ack", i), m_ack, e.ack);
      end
    end
  endtask

  initial begin
    int  n;
    bit  rv_seen;
    bit  gnt_lost;

    //            m_addr m_wd   m_ctl   o_addr o_wd   o_ctl   s_rd   ack  e_addr e_wd  e_ctl   e_rd       e_ack
    vt[0] = '{3'd0, 8'hc8, 3'b111, 3'd0, 8'h00, 3'b000, 8'h00, 1'b0, 3'd0, 8'hc8, 3'b111, 16'h0000, 2'b00};
    vt[1] = '{3'd0, 8'hc8, 3'b111, 3'd0, 8'h00, 3'b000, 8'h00, 1'b1, 3'd0, 8'hc8, 3'b111, 16'h0000, 2'b01};
    vt[2] = '{3'd3, 8'h00, 3'b011, 3'd7, 8'hff, 3'b111, 8'h5a, 1'b1, 3'd3, 8'h00, 3'b011, 16'h005a, 2'b01};
    vt[3] = '{3'd0, 8'h00, 3'b000, 3'd5, 8'h11, 3'b111, 8'h33, 1'b1, 3'd0, 8'h00, 3'b000, 16'h0033, 2'b01};
    vt[4] = '{3'd3, 8'h00, 3'b011, 3'd5, 8'h22, 3'b011, 8'ha5, 1'b0, 3'd3, 8'h00, 3'b011, 16'ha500, 2'b00};
    vt[5] = '{3'd3, 8'h00, 3'b011, 3'd5, 8'h22, 3'b011, 8'ha5, 1'b1, 3'd3, 8'h00, 3'b011, 16'ha500, 2'b10};
    vt[6] = '{3'd3, 8'h00, 3'b011, 3'd5, 8'h22, 3'b000, 8'ha5, 1'b1, 3'd3, 8'h00, 3'b011, 16'ha500, 2'b10};
    vt[7] = '{3'd2, 8'h3c, 3'b111, 3'd1, 8'h44, 3'b111, 8'h00, 1'b1, 3'd2, 8'h3c, 3'b111, 16'h0000, 2'b10};

    rst = 1'b1; req = 2'b00; clear_bus();
    repeat (2) @(negedge clk);
    s_rd = 8'hff; s_ack = 1'b1;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_s_addr", s_addr, 3'd0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_revoke", revoke, 1'b0);
    chk("rst_m_ack", m_ack, 2'b00);
    chk("rst_m_rd", m_rd, 16'h0000);
    s_rd = 8'h00; s_ack = 1'b0;

    // Single requester 0: direct grant, no scrub.
    @(negedge clk); rst = 1'b0; req = 2'b01;
    @(negedge clk);
    chk("a_gnt", gnt, 2'b01);
    chk("a_no_scrub", s_cyc, 1'b0);
    chk("a_owner", owner, 1'b0);
    apply(0, 3, 1'b0);
    @(negedge clk); clear_bus(); req = 2'b00;
    @(negedge clk);
    chk("a_release_gnt", gnt, 2'b00);

    // Owner change to requester 1: scrub held until ack.
    req = 2'b10;
    @(negedge clk);
    chk("b_scrub_gnt", gnt, 2'b00);
    chk("b_scrub_bus", {s_addr, s_wd, s_we, s_stb, s_cyc}, {3'b100, 8'h01, 3'b111});
    chk("b_owner", owner, 1'b1);
    @(negedge clk);
    chk("b_scrub_held", {s_cyc, gnt}, {1'b1, 2'b00});
    s_ack = 1'b1; s_rd = 8'h77;
    #1;
    chk("b_scrub_m_ack", m_ack, 2'b00);
    chk("b_scrub_m_rd", m_rd, 16'h0000);
    @(negedge clk); s_ack = 1'b0; s_rd = 8'h00;
    chk("b_gnt", gnt, 2'b10);
    chk("b_scrub_done", s_cyc, 1'b0);
    apply(4, 7, 1'b1);
    @(negedge clk); clear_bus(); req = 2'b00;
    @(negedge clk);
    chk("b_release_gnt", gnt, 2'b00);

    // Both request: requester 0 wins after 1 owned; then hold-limit revoke.
    req = 2'b11;
    @(negedge clk);
    chk("c_scrub", {owner, gnt, s_cyc}, {1'b0, 2'b00, 1'b1});
    s_ack = 1'b1;
    @(negedge clk); s_ack = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (gnt !== 2'b01) break;
      n++;
      @(negedge clk);
    end
    chk("c_hold_cycles", n, 17);
    chk("c_revoke_pulse", revoke, 1'b1);
    chk("c_revoke_state", {gnt, owner, s_cyc}, {2'b00, 1'b1, 1'b1});
    @(negedge clk);
    chk("c_revoke_single", revoke, 1'b0);
    s_ack = 1'b1;
    @(negedge clk); s_ack = 1'b0;
    chk("c_gnt1", gnt, 2'b10);

    // Owner 1 holds a bus cycle across the limit: revoke waits for cyc low.
    rv_seen = 1'b0; gnt_lost = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      rv_seen  = rv_seen | revoke;
      gnt_lost = gnt_lost | (gnt !== 2'b10);
      if (k == 9) begin m_stb[1] = 1'b1; m_cyc[1] = 1'b1; end
    end
    chk("d_inflight_gnt", {gnt_lost, gnt}, {1'b0, 2'b10});
    chk("d_inflight_no_revoke", rv_seen, 1'b0);
    m_stb[1] = 1'b0; m_cyc[1] = 1'b0;
    @(negedge clk);
    chk("d_deferred_revoke", {revoke, gnt, owner}, {1'b1, 2'b00, 1'b0});
    s_ack = 1'b1;
    @(negedge clk); s_ack = 1'b0;
    chk("d_gnt0", gnt, 2'b01);
    req = 2'b00;
    @(negedge clk);
    chk("d_release", gnt, 2'b00);

    // Reset during scrub drops the bus at once; next grant skips scrub.
    req = 2'b10;
    @(negedge clk);
    chk("e_scrub_cyc", s_cyc, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("e_rst_cyc", s_cyc, 1'b0);
    chk("e_rst_gnt", gnt, 2'b00);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("e_post_rst_gnt", {gnt, s_cyc}, {2'b10, 1'b0});
    chk("e_post_rst_owner", owner, 1'b1);

    // Both request straight out of reset: requester 0 first.
    req = 2'b00;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; req = 2'b11;
    @(negedge clk);
    chk("f_both_after_rst", gnt, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_wb_arbiter.md
Name: i2c_wb_arbiter

Overview:
Shares the single Wishbone slave port of the I2C master core between two transaction sequencers: requester 0 (trusted domain) and requester 1 (untrusted domain, i2c_sys_top-style).
- Ownership is granted per session, not per bus cycle.
- On every change of owner, the arbiter itself runs a scrub write to the core before the new owner gets the bus.
- Read data and acks reach only the current owner; non-owners always see zero.
- The block sits between the sequencers and the I2C core's Wishbone interface.

Parameters:
- MAX_HOLD, 256: max cycles an owner may hold the bus while the other requester waits; 0 disables forced revoke.
- HOLD_W, 9: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.
- SCRUB_DATA, 8'h01: value written to CR (addr 3'b100) on owner change (IACK only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req  in  2  session request, bit i from requester i; held high for the whole transaction.
- gnt  out  2  one-hot session grant.
- m_wb_addr  in  6  {m1,m0} addresses, 3 bits each.
- m_wb_wr_data  in  16  {m1,m0} write data.
- m_wb_we  in  2  per-requester write enable.
- m_wb_stb  in  2  per-requester strobe.
- m_wb_cyc  in  2  per-requester cycle.
- m_wb_rd_data  out  16  {m1,m0} read data, zero for non-owner.
- m_wb_ack  out  2  per-requester ack, zero for non-owner.
- s_wb_addr  out  3  to core.
- s_wb_wr_data  out  8  to core.
- s_wb_we  out  1  to core.
- s_wb_stb  out  1  to core.
- s_wb_cyc  out  1  to core.
- s_wb_rd_data  in  8  from core.
- s_wb_ack  in  1  from core.
- owner_domain  out  1  index of current (or last) owner.
- revoke_err  out  1  one-cycle pulse on forced revoke.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: gnt=0, s_wb_addr=0, s_wb_wr_data=0, s_wb_we/stb/cyc=0, m_wb_ack=0, m_wb_rd_data=0, owner_domain=0, revoke_err=0, hold count=0, state=IDLE, last_owner=1, prev_valid=0.
- Reset mid-operation drops s_wb_cyc immediately and abandons any scrub.
- States: IDLE, SCRUB, OWN.
- IDLE:
  - On any req bit, select a winner. If both are high, the winner is the index != last_owner.
  - If prev_valid=1 and winner != owner_domain, go to SCRUB. Otherwise go to OWN.
  - owner_domain is set to the winner on this transition. gnt rises the cycle after req is sampled, on OWN entry only.
- SCRUB:
  - Drive s_wb_addr=3'b100, s_wb_wr_data=SCRUB_DATA, we=stb=cyc=1. gnt stays 0; all m_wb_ack and m_wb_rd_data are 0.
  - On s_wb_ack: drop stb/cyc/we the next cycle. Then go to OWN if req[owner] is still high, else go to IDLE.
- OWN (owner i):
  - s_wb_* are driven combinationally from requester i's m_wb_* (zero-latency pass-through).
  - m_wb_ack[i]=s_wb_ack and m_wb_rd_data[i]=s_wb_rd_data. The other requester's lanes are 0.
  - Non-owner stb/cyc are ignored entirely.
- Release: when req[i]=0 and m_wb_cyc[i]=0:
  - Go to IDLE, drop gnt next cycle, set last_owner=i and prev_valid=1.
  - If req drops while cyc is high, wait for cyc to fall; a bus cycle is never truncated.
- Hold counter:
  - Cleared on OWN entry. Increments each OWN cycle while the other req is high, and saturates.
  - When MAX_HOLD!=0, count>=MAX_HOLD and m_wb_cyc[i]=0: revoke. Actions: gnt drops, revoke_err pulses for 1 cycle, last_owner=i, go to SCRUB for the other requester.
  - If m_wb_cyc[i]=1 at the limit, defer the revoke until cyc falls.
- Simultaneous events:
  - Release and revoke in the same cycle count as a release (no revoke_err).
  - A new req from the just-released owner in the same cycle as gnt drops is arbitrated normally from IDLE.
- Information-flow labels: req, gnt, owner_domain, the s_wb control lines and revoke_err are {L}. m_wb_rd_data lane i carries the data label of domain i. Zeroing non-owner lanes keeps the labels sound.

Decomposition:
- Shared package i2c_arb_pkg holds:
  - state encodings ST_A_IDLE, ST_A_SCRUB, ST_A_OWN;
  - the CR address 3'b100;
  - the default SCRUB_DATA;
  - requester index constants REQ_TRUSTED=0 and REQ_UNTRUSTED=1.
- One sub-module, i2c_arb_hold_timer: saturating HOLD_W counter with clear/enable inputs and an at_limit output.

Test Plan:
- Reset, then req=2'b01 only → gnt=2'b01 one cycle later with no scrub cycle. m0 write PRER_LO=8'hc8 appears on s_wb. Only m_wb_ack[0] pulses.
- Requester 0 releases, then req=2'b10 → one SCRUB write (addr 3'b100, data 8'h01, held until ack), then gnt=2'b10. owner_domain=1.
- Both req rise together after reset → requester 0 is granted first. After its release, requester 1 is granted with a scrub. Then both rise again → requester 0 is granted (round-robin).
- Owner 1 reads RXR while the core returns 8'hA5 → m_wb_rd_data[15:8]=8'hA5 and m_wb_rd_data[7:0]=0 throughout. m0 stb toggling has no effect on s_wb.
- MAX_HOLD=16; requester 0 holds while req[1]=1 → revoke at the first cyc-low cycle at or after count 16. revoke_err pulses once, a scrub follows, then gnt=2'b10. A cycle in flight at the limit completes first.
- Assert rst during SCRUB with s_wb_cyc=1 → s_wb_cyc=0 immediately, gnt=0. Next grant after reset has no scrub.
